reg_port_arbiter: RTL and testbench



---
 rtl/reg_port_arbiter_pkg.sv | 25 ++
 rtl/reg_port_arbiter_if.sv | 41 ++++
 rtl/reg_port_arbiter_rr_arbiter.sv | 35 +++
 rtl/reg_port_arbiter.sv | 126 ++++++++++++
 tb/tb_reg_port_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_port_arbiter_pkg.sv
// Shared types and helpers for the register-port arbiter.
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   localparam int DEF_AW  = 12;
   localparam int DEF_DW  = 32;
   localparam int DEF_WEW = 4;
   localparam int MAX_REQ = 8;

   // Index of the set bit in a one-hot vector; 0 when no bit is set.
   function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      int unsigned idx;
      idx = 0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/reg_port_arbiter_if.sv
// Requester channels and register-file port bundled for the arbiter.
//
// Handshake: a requester raises req_valid with a stable payload and keeps
// it until req_ready pulses for exactly one cycle; the transfer happens in
// that cycle. rsp_valid pulses once later and qualifies rsp_rdata. There is
// no backpressure on the response side.
interface reg_port_arbiter_if
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int WEW     = DEF_WEW
);
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ*AW-1:0]  req_addr;
   logic [NUM_REQ*WEW-1:0] req_we;
   logic [NUM_REQ*DW-1:0]  req_wdata;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [DW-1:0]          rsp_rdata;
   logic                   busy;
   logic                   reg_en;
   logic [AW-1:0]          reg_addr;
   logic [WEW-1:0]         reg_we;
   logic [DW-1:0]          reg_din;
   logic [DW-1:0]          reg_dout;
   state_t                 state;

   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, reg_dout,
      output req_ready, rsp_valid, rsp_rdata, busy,
             reg_en, reg_addr, reg_we, reg_din, state
   );

   modport master (
      output req_valid, req_addr, req_we, req_wdata, reg_dout,
      input  req_ready, rsp_valid, rsp_rdata, busy,
             reg_en, reg_addr, reg_we, reg_din, state
   );
endinterface

// File: rtl/reg_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts at ptr and wraps to 0.
module rr_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IW-1:0]      idx,
   output logic               any
);

   // First requester found walking upward from the pointer wins.
   always_comb begin
      int   j;
      logic found;
      gnt   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         if (!found && req[j]) begin
            gnt[j] = 1'b1;
            found  = 1'b1;
         end
      end
   end

   assign idx = IW'(onehot_to_idx(MAX_REQ'(gnt)));
   assign any = |req;

endmodule

// File: rtl/reg_port_arbiter.sv
// Shares one register-file port between NUM_REQ requesters, round-robin.
// One access every three cycles: IDLE (pick) -> ACCESS (drive port,
// ready pulse) -> CAPTURE (latch read data) -> IDLE (response pulse).
module reg_port_arbiter
   import reg_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int AW      = DEF_AW,
   parameter int DW      = DEF_DW,
   parameter int WEW     = DEF_WEW
) (
   input logic                clk,
   input logic                rst_n,
   reg_port_arbiter_if.slave  bus
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t             state_q, state_d;
   logic [IW-1:0]      ptr_q;
   logic [NUM_REQ-1:0] grant_q;
   logic [IW-1:0]      win_q;
   logic [WEW-1:0]     we_lat_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic [DW-1:0]      rsp_rdata_q;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IW-1:0]      arb_idx;
   logic               arb_any;

   logic               reg_en_c;
   logic [AW-1:0]      reg_addr_c;
   logic [WEW-1:0]     reg_we_c;
   logic [DW-1:0]      reg_din_c;
   logic [NUM_REQ-1:0] req_ready_c;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr (
      .req (bus.req_valid),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and port drive; the port is zeroed whenever reg_en is low.
   always_comb begin
      state_d     = state_q;
      reg_en_c    = 1'b0;
      reg_addr_c  = '0;
      reg_we_c    = '0;
      reg_din_c   = '0;
      req_ready_c = '0;
      unique case (state_q)
         IDLE: begin
            if (arb_any) state_d = ACCESS;
         end
         ACCESS: begin
            if (bus.req_valid[win_q]) begin
               reg_en_c    = 1'b1;
               reg_addr_c  = bus.req_addr[int'(win_q)*AW +: AW];
               reg_we_c    = bus.req_we[int'(win_q)*WEW +: WEW];
               reg_din_c   = bus.req_wdata[int'(win_q)*DW +: DW];
               req_ready_c = grant_q;
               state_d     = CAPTURE;
            end else begin
               // Winner withdrew: drop the slot, keep the advanced pointer.
               state_d = IDLE;
            end
         end
         CAPTURE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant/pointer bookkeeping, write-enable latch and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         grant_q     <= '0;
         win_q       <= '0;
         we_lat_q    <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= '0;
         unique case (state_q)
            IDLE: begin
               if (arb_any) begin
                  grant_q <= arb_gnt;
                  win_q   <= arb_idx;
                  ptr_q   <= (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + IW'(1);
               end
            end
            ACCESS: begin
               if (reg_en_c) we_lat_q <= reg_we_c;
            end
            CAPTURE: begin
               // Write data is not echoed; reg_dout is stale after a write.
               rsp_rdata_q <= (we_lat_q == '0) ? bus.reg_dout : '0;
               rsp_valid_q <= grant_q;
            end
            default: ;
         endcase
      end
   end

   assign bus.req_ready = req_ready_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.reg_en    = reg_en_c;
   assign bus.reg_addr  = reg_addr_c;
   assign bus.reg_we    = reg_we_c;
   assign bus.reg_din   = reg_din_c;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Directed bench for reg_port_arbiter with a small register-file model.
module tb_reg_port_arbiter;
   import reg_arb_pkg::*;

   localparam int NUM_REQ = 2;
   localparam int AW      = 12;
   localparam int DW      = 32;
   localparam int WEW     = 4;
   localparam logic [DW-1:0] ALARM_IN1 = 32'h0000_1357;

   logic clk;
   logic rst_n;
   logic [DW-1:0] reg_dout_q = '0;

   int errors = 0;
   int checks = 0;

   reg_port_arbiter_if #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .WEW(WEW)) bus ();

   reg_port_arbiter #(.NUM_REQ(NUM_REQ), .AW(AW), .DW(DW), .WEW(WEW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: registered read, writes leave dout untouched.
   function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
      case (a)
         12'h000: return 32'h0000_8000;
         12'h004: return 32'h0002_0000;
         12'h0c0: return ALARM_IN1;
         default: return 32'hA5A5_0000 | DW'(a);
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus.reg_en && bus.reg_we == '0) reg_dout_q <= model_rd(bus.reg_addr);
   end
   assign bus.reg_dout = reg_dout_q;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int i, input logic v, input logic [AW-1:0] a,
                            input logic [WEW-1:0] w, input logic [DW-1:0] d);
      bus.req_valid[i]           = v;
      bus.req_addr[i*AW +: AW]   = a;
      bus.req_we[i*WEW +: WEW]   = w;
      bus.req_wdata[i*DW +: DW]  = d;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_addr  = '0;
      bus.req_we    = '0;
      bus.req_wdata = '0;
      step();
      step();

      // Reset state.
      check("rst_state",  64'(bus.state), 64'(IDLE));
      check("rst_ready",  64'(bus.req_ready), 64'(0));
      check("rst_rspv",   64'(bus.rsp_valid), 64'(0));
      check("rst_rdata",  64'(bus.rsp_rdata), 64'(0));
      check("rst_en",     64'(bus.reg_en), 64'(0));
      check("rst_busy",   64'(bus.busy), 64'(0));
      rst_n = 1'b1;
      step();

      // Single read from requester 0.
      drive_req(0, 1'b1, 12'h004, 4'h0, 32'h0);
      #1;
      check("rd_idle_busy", 64'(bus.busy), 64'(0));
      step();
      check("rd_ready", 64'(bus.req_ready), 64'(2'b01));
      check("rd_en",    64'(bus.reg_en), 64'(1));
      check("rd_addr",  64'(bus.reg_addr), 64'(12'h004));
      check("rd_we",    64'(bus.reg_we), 64'(0));
      step();
      drive_req(0, 1'b0, 12'h0, 4'h0, 32'h0);
      #1;
      check("rd_cap_state", 64'(bus.state), 64'(CAPTURE));
      check("rd_cap_en",    64'(bus.reg_en), 64'(0));
      check("rd_cap_ready", 64'(bus.req_ready), 64'(0));
      step();
      check("rd_rspv",  64'(bus.rsp_valid), 64'(2'b01));
      check("rd_rdata", 64'(bus.rsp_rdata), 64'(32'h0002_0000));
      step();
      check("rd_rspv_pulse", 64'(bus.rsp_valid), 64'(0));
      check("rd_rdata_hold", 64'(bus.rsp_rdata), 64'(32'h0002_0000));

      // Single write from requester 1 (pointer now at 1).
      drive_req(1, 1'b1, 12'h0c0, 4'hF, 32'hDEAD_BEEF);
      #1;
      step();
      check("wr_ready", 64'(bus.req_ready), 64'(2'b10));
      check("wr_en",    64'(bus.reg_en), 64'(1));
      check("wr_addr",  64'(bus.reg_addr), 64'(12'h0c0));
      check("wr_we",    64'(bus.reg_we), 64'(4'hF));
      check("wr_din",   64'(bus.reg_din), 64'(32'hDEAD_BEEF));
      step();
      drive_req(1, 1'b0, 12'h0, 4'h0, 32'h0);
      #1;
      check("wr_cap_en",  64'(bus.reg_en), 64'(0));
      check("wr_cap_din", 64'(bus.reg_din), 64'(0));
      step();
      check("wr_rspv",  64'(bus.rsp_valid), 64'(2'b10));
      check("wr_rdata", 64'(bus.rsp_rdata), 64'(0));

      // Round-robin: both requesters hold reads for six grants.
      drive_req(0, 1'b1, 12'h000, 4'h0, 32'h0);
      drive_req(1, 1'b1, 12'h0c0, 4'h0, 32'h0);
      #1;
      for (int g = 0; g < 6; g++) begin
         logic [NUM_REQ-1:0] exp_oh;
         logic [DW-1:0]      exp_data;
         exp_oh   = (g % 2 == 0) ? 2'b01 : 2'b10;
         exp_data = (g % 2 == 0) ? 32'h0000_8000 : ALARM_IN1;
         step();
         check($sformatf("rr_ready_%0d", g), 64'(bus.req_ready), 64'(exp_oh));
         check($sformatf("rr_addr_%0d", g),  64'(bus.reg_addr),
               64'((g % 2 == 0) ? 12'h000 : 12'h0c0));
         step();
         step();
         if (g == 5) begin
            drive_req(0, 1'b0, 12'h0, 4'h0, 32'h0);
            drive_req(1, 1'b0, 12'h0, 4'h0, 32'h0);
         end
         check($sformatf("rr_rspv_%0d", g),  64'(bus.rsp_valid), 64'(exp_oh));
         check($sformatf("rr_rdata_%0d", g), 64'(bus.rsp_rdata), 64'(exp_data));
      end

      // Withdraw: requester 0 valid for a single cycle.
      drive_req(0, 1'b1, 12'h004, 4'h0, 32'h0);
      #1;
      step();
      drive_req(0, 1'b0, 12'h004, 4'h0, 32'h0);
      #1;
      check("wd_state", 64'(bus.state), 64'(ACCESS));
      check("wd_en",    64'(bus.reg_en), 64'(0));
      check("wd_ready", 64'(bus.req_ready), 64'(0));
      step();
      check("wd_idle", 64'(bus.state), 64'(IDLE));
      step();
      check("wd_no_rsp", 64'(bus.rsp_valid), 64'(0));
      drive_req(0, 1'b1, 12'h004, 4'h0, 32'h0);
      drive_req(1, 1'b1, 12'h0c0, 4'h0, 32'h0);
      #1;
      step();
      check("wd_next_ready", 64'(bus.req_ready), 64'(2'b10));
      check("wd_next_addr",  64'(bus.reg_addr), 64'(12'h0c0));
      step();
      drive_req(0, 1'b0, 12'h0, 4'h0, 32'h0);
      drive_req(1, 1'b0, 12'h0, 4'h0, 32'h0);
      step();
      check("wd_next_rspv",  64'(bus.rsp_valid), 64'(2'b10));
      check("wd_next_rdata", 64'(bus.rsp_rdata), 64'(ALARM_IN1));

      // Reset during CAPTURE.
      drive_req(0, 1'b1, 12'h000, 4'h0, 32'h0);
      #1;
      step();
      check("rm_ready", 64'(bus.req_ready), 64'(2'b01));
      step();
      drive_req(0, 1'b0, 12'h0, 4'h0, 32'h0);
      #1;
      check("rm_cap_state", 64'(bus.state), 64'(CAPTURE));
      rst_n = 1'b0;
      #1;
      check("rm_state", 64'(bus.state), 64'(IDLE));
      check("rm_busy",  64'(bus.busy), 64'(0));
      check("rm_rdata", 64'(bus.rsp_rdata), 64'(0));
      check("rm_rspv",  64'(bus.rsp_valid), 64'(0));
      check("rm_en",    64'(bus.reg_en), 64'(0));
      step();
      check("rm_hold_rspv", 64'(bus.rsp_valid), 64'(0));
      step();
      rst_n = 1'b1;
      step();
      check("rm_post_rspv0", 64'(bus.rsp_valid), 64'(0));
      step();
      check("rm_post_rspv1", 64'(bus.rsp_valid), 64'(0));
      drive_req(0, 1'b1, 12'h004, 4'h0, 32'h0);
      drive_req(1, 1'b1, 12'h0c0, 4'h0, 32'h0);
      #1;
      step();
      check("rm_first_grant", 64'(bus.req_ready), 64'(2'b01));
      check("rm_first_addr",  64'(bus.reg_addr), 64'(12'h004));
      step();
      drive_req(0, 1'b0, 12'h0, 4'h0, 32'h0);
      drive_req(1, 1'b0, 12'h0, 4'h0, 32'h0);
      step();
      check("rm_first_rspv",  64'(bus.rsp_valid), 64'(2'b01));
      check("rm_first_rdata", 64'(bus.rsp_rdata), 64'(32'h0002_0000));

      // Idle quiescence for 20 cycles.
      for (int c = 0; c < 20; c++) begin
         step();
         check($sformatf("q_en_%0d", c),    64'(bus.reg_en), 64'(0));
         check($sformatf("q_busy_%0d", c),  64'(bus.busy), 64'(0));
         check($sformatf("q_ready_%0d", c), 64'(bus.req_ready), 64'(0));
         check($sformatf("q_rspv_%0d", c),  64'(bus.rsp_valid), 64'(0));
         check($sformatf("q_addr_%0d", c),  64'(bus.reg_addr), 64'(0));
         check($sformatf("q_din_%0d", c),   64'(bus.reg_din), 64'(0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
